// File: rtl/selector_mode_sequencer.sv
// Sequences datapath mode changes from the selector pins: debounce, hold/drain,
// clear pulse, then commit. All outputs are registered from the next-state decode.
module selector_mode_sequencer #(
    parameter int unsigned SEL_W         = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter int unsigned CLEAR_CYCLES  = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [SEL_W-1:0] i_selector_in,
    input  logic             i_dp_idle,
    output logic [SEL_W-1:0] o_mode,
    output logic             o_mode_valid,
    output logic             o_dp_hold,
    output logic             o_dp_clear,
    output logic             o_switch_pulse,
    output logic             o_timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StDrain,
        StClear,
        StApply
    } state_e;

    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DrainLast  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ClearLast  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e             r_state;
    state_e             w_state_d;
    logic [SEL_W-1:0]   r_sel_q;
    logic [SEL_W-1:0]   r_cand;
    logic [SEL_W-1:0]   w_cand_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [SEL_W-1:0]   r_mode;
    logic [SEL_W-1:0]   w_mode_d;
    logic               r_timeout_err;
    logic               w_timeout_err_d;
    logic               r_mode_valid;
    logic               r_dp_hold;
    logic               r_dp_clear;
    logic               r_switch_pulse;
    logic               w_hold_d;
    logic               w_clear_d;
    logic               w_pulse_d;

    always_comb begin
        w_state_d       = r_state;
        w_cand_d        = r_cand;
        w_cnt_d         = r_cnt;
        w_mode_d        = r_mode;
        w_timeout_err_d = r_timeout_err;
        case (r_state)
            StIdle: begin
                if (r_sel_q != r_mode) begin
                    w_state_d = StSettle;
                    w_cand_d  = r_sel_q;
                    w_cnt_d   = '0;
                end
            end
            StSettle: begin
                if (r_sel_q == r_mode) begin
                    w_state_d = StIdle;
                end else if (r_sel_q != r_cand) begin
                    // A new candidate restarts the debounce window.
                    w_cand_d = r_sel_q;
                    w_cnt_d  = '0;
                end else if (r_cnt == SettleLast) begin
                    w_state_d = StDrain;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            StDrain: begin
                if (i_dp_idle) begin
                    w_state_d = StClear;
                    w_cnt_d   = '0;
                end else if (r_cnt == DrainLast) begin
                    w_state_d       = StClear;
                    w_cnt_d         = '0;
                    w_timeout_err_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            StClear: begin
                if (r_cnt == ClearLast) begin
                    w_state_d = StApply;
                    w_mode_d  = r_cand;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            StApply: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs follow the state being entered so they change on the same edge.
    always_comb begin
        w_hold_d  = (w_state_d == StDrain) || (w_state_d == StClear) || (w_state_d == StApply);
        w_clear_d = (w_state_d == StClear);
        w_pulse_d = (w_state_d == StApply);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_sel_q        <= '0;
            r_cand         <= '0;
            r_cnt          <= '0;
            r_mode         <= '0;
            r_timeout_err  <= 1'b0;
            r_mode_valid   <= 1'b1;
            r_dp_hold      <= 1'b0;
            r_dp_clear     <= 1'b0;
            r_switch_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_sel_q        <= i_selector_in;
            r_cand         <= w_cand_d;
            r_cnt          <= w_cnt_d;
            r_mode         <= w_mode_d;
            r_timeout_err  <= w_timeout_err_d;
            r_mode_valid   <= !w_hold_d;
            r_dp_hold      <= w_hold_d;
            r_dp_clear     <= w_clear_d;
            r_switch_pulse <= w_pulse_d;
        end
    end

    assign o_mode         = r_mode;
    assign o_mode_valid   = r_mode_valid;
    assign o_dp_hold      = r_dp_hold;
    assign o_dp_clear     = r_dp_clear;
    assign o_switch_pulse = r_switch_pulse;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_selector_mode_sequencer.sv
// Bench for selector_mode_sequencer: fixed vector table, directed corner sequences,
// then randomized traffic against a phase/age reference model.
module tb_selector_mode_sequencer;

    localparam int SETTLE = 4;
    localparam int DRAINT = 16;
    localparam int CLEARC = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel_in;
    logic       dp_idle;
    logic [1:0] mode;
    logic       mode_valid;
    logic       dp_hold;
    logic       dp_clear;
    logic       switch_pulse;
    logic       timeout_err;

    int n_vec;
    int n_err;

    selector_mode_sequencer dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_selector_in  (sel_in),
        .i_dp_idle      (dp_idle),
        .o_mode         (mode),
        .o_mode_valid   (mode_valid),
        .o_dp_hold      (dp_hold),
        .o_dp_clear     (dp_clear),
        .o_switch_pulse (switch_pulse),
        .o_timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 settle, 2 drain, 3 clear, 4 apply;
    // m_age is the number of cycles spent so far in the current phase.
    int         m_phase;
    int         m_age;
    logic [1:0] m_selq;
    logic [1:0] m_cand;
    logic [1:0] m_mode;
    bit         m_terr;

    task automatic model_edge(input bit rst, input logic [1:0] sel, input bit idle);
        if (!rst) begin
            m_phase = 0; m_age = 0; m_selq = 2'b00; m_cand = 2'b00; m_mode = 2'b00;
            m_terr = 1'b0;
            return;
        end
        case (m_phase)
            0: if (m_selq != m_mode) begin m_phase = 1; m_cand = m_selq; m_age = 1; end
            1: begin
                if (m_selq == m_mode) m_phase = 0;
                else if (m_selq != m_cand) begin m_cand = m_selq; m_age = 1; end
                else if (m_age >= SETTLE) begin m_phase = 2; m_age = 1; end
                else m_age++;
            end
            2: begin
                if (idle) begin m_phase = 3; m_age = 1; end
                else if (m_age >= DRAINT) begin m_phase = 3; m_age = 1; m_terr = 1'b1; end
                else m_age++;
            end
            3: begin
                if (m_age >= CLEARC) begin m_phase = 4; m_mode = m_cand; end
                else m_age++;
            end
            default: m_phase = 0;
        endcase
        m_selq = sel;
    endtask

    function automatic logic [6:0] model_word();
        bit busy;
        busy = (m_phase >= 2);
        return {m_mode, !busy, busy, m_phase == 3, m_phase == 4, m_terr};
    endfunction

    function automatic logic [6:0] dut_word();
        return {mode, mode_valid, dp_hold, dp_clear, switch_pulse, timeout_err};
    endfunction

    task automatic step(input bit rst, input logic [1:0] sel, input bit idle);
        rst_n   = rst;
        sel_in  = sel;
        dp_idle = idle;
        @(posedge clk);
        model_edge(rst, sel, idle);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] sel;
        bit         idle;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input logic [1:0] sel, input bit idle,
                       input logic [1:0] m, input bit v, input bit h, input bit c,
                       input bit p, input bit t);
        vec_t r;
        r.rst = rst; r.sel = sel; r.idle = idle; r.exp = {m, v, h, c, p, t};
        tbl.push_back(r);
    endtask

    // Ten cycles of a clean switch with dp_idle=1: sample, 4 settle, drain,
    // 2 clear, apply, back to idle.
    task automatic add_switch(input logic [1:0] sel, input logic [1:0] from,
                              input logic [1:0] to, input bit t);
        for (int i = 0; i < 5; i++) add(1, sel, 1, from, 1, 0, 0, 0, t);
        add(1, sel, 1, from, 0, 1, 0, 0, t);
        add(1, sel, 1, from, 0, 1, 1, 0, t);
        add(1, sel, 1, from, 0, 1, 1, 0, t);
        add(1, sel, 1, to,   0, 1, 0, 1, t);
        add(1, sel, 1, to,   1, 0, 0, 0, t);
    endtask

    initial begin
        int cnt;
        bit seen;
        bit bias;
        logic [1:0] rsel;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; sel_in = 2'b10; dp_idle = 1'b1;

        // Reset with selector at 10, then switch to 10, back to 00, then 11.
        for (int i = 0; i < 3; i++) add(0, 2'b10, 1, 2'b00, 1, 0, 0, 0, 0);
        add_switch(2'b10, 2'b00, 2'b10, 0);
        add_switch(2'b00, 2'b10, 2'b00, 0);
        add_switch(2'b11, 2'b00, 2'b11, 0);
        // Bounce 11->10->11: no hold ever.
        add(1, 2'b10, 1, 2'b11, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 2'b11, 1, 2'b11, 1, 0, 0, 0, 0);
        // 11->00 for two cycles then 01: debounce restarts on the 01 sample.
        add(1, 2'b00, 1, 2'b11, 1, 0, 0, 0, 0);
        add(1, 2'b00, 1, 2'b11, 1, 0, 0, 0, 0);
        add_switch(2'b01, 2'b11, 2'b01, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].sel, tbl[i].idle);
            chk($sformatf("table[%0d]", i), {1'b0, dut_word()}, {1'b0, tbl[i].exp});
        end

        // Drain held 5 cycles by dp_idle=0, selector toggled mid-drain.
        for (int i = 0; i < 5; i++) step(1, 2'b10, 0);
        step(1, 2'b10, 0);
        chk("t4_drain_entry", {6'd0, dp_hold, mode_valid}, 8'h02);
        for (int i = 0; i < 4; i++) step(1, 2'b11, 0);
        chk("t4_still_drain", {6'd0, dp_hold, dp_clear}, 8'h02);
        step(1, 2'b10, 1);
        chk("t4_clear", {7'd0, dp_clear}, 8'h01);
        step(1, 2'b10, 1);
        step(1, 2'b10, 1);
        chk("t4_apply", {4'd0, mode, switch_pulse, timeout_err}, 8'h0a);
        step(1, 2'b10, 1);
        chk("t4_idle", {6'd0, dp_hold, mode_valid}, 8'h01);

        // Drain never idles: timeout after exactly 16 drain cycles.
        for (int i = 0; i < 5; i++) step(1, 2'b00, 0);
        cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1, 2'b00, 0);
            if (dp_clear) seen = 1;
            else if (dp_hold) cnt++;
        end
        chk("t5_clear_seen", {7'd0, seen}, 8'h01);
        chk("t5_drain_len", cnt[7:0], 8'd16);
        chk("t5_err_set", {7'd0, timeout_err}, 8'h01);
        for (int i = 0; i < 3; i++) step(1, 2'b00, 1);
        chk("t5_mode", {6'd0, mode}, 8'h00);
        for (int i = 0; i < 12; i++) step(1, 2'b01, 1);
        chk("t5_sticky", {5'd0, mode, timeout_err}, 8'h03);

        // Reset asserted in the middle of CLEAR.
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 2'b11, 1);
            if (dp_clear) seen = 1;
        end
        chk("t6_in_clear", {7'd0, seen}, 8'h01);
        step(0, 2'b11, 1);
        chk("t6_reset", {1'b0, dut_word()}, {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) step(1, 2'b00, 1);

        // Randomized traffic against the model.
        bias = 0;
        rsel = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) bias = ~bias;
            if ($urandom_range(0, 5) == 0) rsel = 2'($urandom_range(0, 3));
            step($urandom_range(0, 149) != 0, rsel,
                 bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0));
            chk("random", {1'b0, dut_word()}, {1'b0, model_word()});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
